// File: rtl/regbank_pkg.sv
// +--------------------------------------------------------------------------+
// | regbank_pkg : shared constants and index type for the register bank      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package regbank_pkg;

  localparam int REG_COUNT      = 16;
  localparam int REG_INDEX_BITS = 4;
  localparam int PC_INDEX       = 15;

  typedef logic [REG_INDEX_BITS-1:0] reg_index_t;

  // One-hot decode of a register index.
  function automatic logic [REG_COUNT-1:0] decode_index(input reg_index_t idx);
    logic [REG_COUNT-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/n_bits_register_read_port.sv
// +--------------------------------------------------------------------------+
// | n_bits_register_read_port : one read port of the register bank           |
// |   16:1 mux, same-cycle write forwarding, PC read offset on R15            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module n_bits_register_read_port
  import regbank_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int PC_READ_OFFSET = 8,
  parameter bit BYPASS         = 1'b1
) (
  input  logic [REG_COUNT*BITS-1:0] registers,
  input  reg_index_t                read_address,
  input  logic                      forward_valid,
  input  reg_index_t                write_address,
  input  logic [BITS-1:0]           write_data,
  output logic [BITS-1:0]           read_data
);

  localparam logic            c_bypass_en = BYPASS;
  localparam logic [BITS-1:0] c_offset    = BITS'(PC_READ_OFFSET);

  logic [BITS-1:0] w_entries [REG_COUNT];
  logic [BITS-1:0] w_raw;
  logic [BITS-1:0] w_offset;
  logic            w_forward;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_entry
    assign w_entries[i] = registers[i*BITS +: BITS];
  end

  assign w_forward = c_bypass_en && forward_valid && (write_address == read_address);
  assign w_raw     = w_forward ? write_data : w_entries[read_address];

  // Offset is applied after forwarding, so a forwarded branch target also reads as PC+offset.
  assign w_offset  = (read_address == reg_index_t'(PC_INDEX)) ? c_offset : '0;
  assign read_data = w_raw + w_offset;

endmodule

`default_nettype wire

// File: rtl/n_bits_sixteen_register_bank.sv
// +--------------------------------------------------------------------------+
// | n_bits_sixteen_register_bank : R0-R15 architectural registers, R15 = PC  |
// |   write decoder, sixteen registers, two combinational read ports         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module n_bits_sixteen_register_bank
  import regbank_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int PC_READ_OFFSET = 8,
  parameter bit BYPASS         = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WRITE_ENABLE,
  input  reg_index_t                WRITE_ADDRESS,
  input  logic [BITS-1:0]           WRITE_DATA,
  input  logic                      PC_ENABLE,
  input  logic [BITS-1:0]           PC_NEXT,
  input  reg_index_t                READ_ADDRESS_A,
  input  reg_index_t                READ_ADDRESS_B,
  output logic [BITS-1:0]           READ_DATA_A,
  output logic [BITS-1:0]           READ_DATA_B,
  output logic [REG_COUNT*BITS-1:0] REGISTERS
);

  logic [REG_COUNT-1:0] w_write_sel;
  logic                 w_forward_valid;

  assign w_write_sel     = WRITE_ENABLE ? decode_index(WRITE_ADDRESS) : '0;
  assign w_forward_valid = WRITE_ENABLE && !RESET;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    logic [BITS-1:0] r_value;

    if (i == PC_INDEX) begin : g_pc
      // An explicit write (branch) wins over the sequential PC_NEXT load.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_value <= '0;
        end else if (w_write_sel[i]) begin
          r_value <= WRITE_DATA;
        end else if (PC_ENABLE) begin
          r_value <= PC_NEXT;
        end
      end
    end else begin : g_gpr
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_value <= '0;
        end else if (w_write_sel[i]) begin
          r_value <= WRITE_DATA;
        end
      end
    end

    assign REGISTERS[i*BITS +: BITS] = r_value;
  end

  n_bits_register_read_port #(
    .BITS           (BITS),
    .PC_READ_OFFSET (PC_READ_OFFSET),
    .BYPASS         (BYPASS)
  ) u_read_port_a (
    .registers     (REGISTERS),
    .read_address  (READ_ADDRESS_A),
    .forward_valid (w_forward_valid),
    .write_address (WRITE_ADDRESS),
    .write_data    (WRITE_DATA),
    .read_data     (READ_DATA_A)
  );

  n_bits_register_read_port #(
    .BITS           (BITS),
    .PC_READ_OFFSET (PC_READ_OFFSET),
    .BYPASS         (BYPASS)
  ) u_read_port_b (
    .registers     (REGISTERS),
    .read_address  (READ_ADDRESS_B),
    .forward_valid (w_forward_valid),
    .write_address (WRITE_ADDRESS),
    .write_data    (WRITE_DATA),
    .read_data     (READ_DATA_B)
  );

endmodule

`default_nettype wire

// File: tb/tb_n_bits_sixteen_register_bank.sv
// +--------------------------------------------------------------------------+
// | tb_n_bits_sixteen_register_bank : bench for the register bank, bypassing |
// |   and non-bypassing instances driven in lockstep                         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_n_bits_sixteen_register_bank;

  logic         clk = 1'b0;
  logic         rst, we, pce;
  logic [3:0]   wa, ra, rb;
  logic [31:0]  wd, pcn;
  logic [31:0]  rd_a, rd_b, rd_a_nb, rd_b_nb;
  logic [511:0] regs, regs_nb;

  logic [31:0]  model [16];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  n_bits_sixteen_register_bank #(.BITS(32), .PC_READ_OFFSET(8), .BYPASS(1'b1)) dut (
    .CLK(clk), .RESET(rst), .WRITE_ENABLE(we), .WRITE_ADDRESS(wa), .WRITE_DATA(wd),
    .PC_ENABLE(pce), .PC_NEXT(pcn), .READ_ADDRESS_A(ra), .READ_ADDRESS_B(rb),
    .READ_DATA_A(rd_a), .READ_DATA_B(rd_b), .REGISTERS(regs)
  );

  n_bits_sixteen_register_bank #(.BITS(32), .PC_READ_OFFSET(8), .BYPASS(1'b0)) dut_nb (
    .CLK(clk), .RESET(rst), .WRITE_ENABLE(we), .WRITE_ADDRESS(wa), .WRITE_DATA(wd),
    .PC_ENABLE(pce), .PC_NEXT(pcn), .READ_ADDRESS_A(ra), .READ_ADDRESS_B(rb),
    .READ_DATA_A(rd_a_nb), .READ_DATA_B(rd_b_nb), .REGISTERS(regs_nb)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural view of a read: forwarded write if enabled, else stored value; R15 reads as PC+8.
  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit byp);
    logic [31:0] v;
    v = model[a];
    if (byp && we && !rst && wa == a) v = wd;
    if (a == 4'd15) v = v + 32'd8;
    return v;
  endfunction

  function automatic logic [511:0] model_bus();
    logic [511:0] bus;
    for (int i = 0; i < 16; i++) bus[i*32 +: 32] = model[i];
    return bus;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic pe, input logic [31:0] pn, input logic [3:0] xa, input logic [3:0] xb);
    @(negedge clk);
    rst = r; we = w; wa = a; wd = d; pce = pe; pcn = pn; ra = xa; rb = xb;
    #1;
    chk("read_a_byp",   rd_a,    exp_read(ra, 1'b1));
    chk("read_b_byp",   rd_b,    exp_read(rb, 1'b1));
    chk("read_a_nobyp", rd_a_nb, exp_read(ra, 1'b0));
    chk("read_b_nobyp", rd_b_nb, exp_read(rb, 1'b0));
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
    end else begin
      if (we) model[wa] = wd;
      if (pce && !(we && wa == 4'd15)) model[15] = pcn;
    end
    #1;
    chk("regs_byp",   regs,    model_bus());
    chk("regs_nobyp", regs_nb, model_bus());
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; pce = 1'b0; wa = '0; wd = '0; pcn = '0; ra = '0; rb = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;

    // Initial reset; model already holds zeros so reads can be checked before the edge
    drive(1, 0, 0, 0, 0, 0, 0, 15); clock();
    chk("reset_state", regs, 512'd0);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), 32'hFFFF_FFFF, 0, 0, 4'(i), 15); clock();
    end
    chk("preload", regs, {16{32'hFFFF_FFFF}});

    // Reset overrides a write and a PC load in the same cycle
    drive(1, 1, 3, 32'h55, 1, 32'h999, 15, 3); clock();
    chk("reset_clears", regs, 512'd0);
    drive(0, 0, 0, 0, 0, 0, 15, 0);
    chk("pc_read_after_reset", rd_a, 32'h8);
    clock();

    // Write R5 with forwarding on port B
    drive(0, 1, 5, 32'h1234_5678, 0, 0, 0, 5);
    chk("bypass_b", rd_b, 32'h1234_5678);
    chk("nobypass_b_old", rd_b_nb, 32'h0);
    clock();
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    chk("r5_read_a", rd_a_nb, 32'h1234_5678);
    clock();

    // PC advance then stall
    drive(0, 0, 0, 0, 1, 32'h100, 0, 0); clock();
    chk("pc_load", regs[15*32 +: 32], 32'h100);
    drive(0, 0, 0, 0, 0, 32'h104, 15, 0);
    chk("pc_plus_offset", rd_a, 32'h108);
    clock();
    chk("pc_stall", regs[15*32 +: 32], 32'h100);

    // Branch write beats PC_NEXT
    drive(0, 1, 15, 32'h400, 1, 32'h200, 0, 0); clock();
    chk("branch_priority", regs[15*32 +: 32], 32'h400);

    // Offset wrap-around
    drive(0, 1, 15, 32'hFFFF_FFFC, 0, 0, 0, 0); clock();
    drive(0, 0, 0, 0, 0, 0, 0, 15);
    chk("wrap_read_b", rd_b, 32'h4);
    chk("wrap_raw", regs[15*32 +: 32], 32'hFFFF_FFFC);
    clock();

    // GPR write and PC load in the same cycle
    drive(0, 1, 14, 32'hA, 1, 32'h20, 14, 14); clock();
    chk("simul_r14", regs[14*32 +: 32], 32'hA);
    chk("simul_r15", regs[15*32 +: 32], 32'h20);
    drive(0, 0, 0, 0, 0, 0, 14, 14);
    chk("simul_read_a", rd_a, 32'hA);
    chk("simul_read_b", rd_b, 32'hA);
    clock();

    // Randomized traffic, biased toward R15 and read-after-write hazards
    for (int n = 0; n < 400; n++) begin
      logic       r, w, pe;
      logic [3:0] a, xa, xb;
      r  = ($urandom_range(0, 31) == 0);
      w  = $urandom_range(0, 1) == 1;
      pe = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      xa = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
      xb = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
      drive(r, w, a, $urandom, pe, $urandom, xa, xb);
      clock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/n_bits_sixteen_register_bank.md
Name: n_bits_sixteen_register_bank

Overview:
- Sixteen-entry, BITS-wide architectural register bank (R0–R15) for the ARMv4 datapath. Sits directly upstream of the 16:1 four-bit-select read multiplexers.
- Exports all registers as a packed 16×BITS bus and provides two read ports (A, B) built from those multiplexers.
- R15 is the program counter. It loads the next-PC every enabled cycle unless it is explicitly written.

Parameters:
- BITS, 32, register width.
- PC_READ_OFFSET, 8, constant added (mod 2^BITS) to R15 when R15 is read through port A or B (ARM pipeline PC+8).
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return the registered value only.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- WRITE_ENABLE  in  1  commit WRITE_DATA to WRITE_ADDRESS at the next edge
- WRITE_ADDRESS  in  4  destination register index
- WRITE_DATA  in  BITS  value to write
- PC_ENABLE  in  1  R15 advances to PC_NEXT at the next edge (0 = stall, hold R15)
- PC_NEXT  in  BITS  next program counter
- READ_ADDRESS_A  in  4  port A index
- READ_ADDRESS_B  in  4  port B index
- READ_DATA_A  out  BITS  port A data (combinational)
- READ_DATA_B  out  BITS  port B data (combinational)
- REGISTERS  out  16×BITS  packed raw register contents, entry i = Ri, no offset applied

Behaviour:
- One clock; reset is synchronous and active-high: clock port CLK, reset port RESET.
- Reset: on a rising CLK edge with RESET=1, all sixteen registers become 0. RESET overrides WRITE_ENABLE and PC_ENABLE. A write or PC load in that cycle is discarded.
- After reset, REGISTERS = all zero, and READ_DATA_x = 0 for x addressing R0–R14. READ_DATA_x = PC_READ_OFFSET for x addressing R15.
- Write, R0–R14: if WRITE_ENABLE=1 and WRITE_ADDRESS≠15, Rw ← WRITE_DATA at the edge. Latency 1 cycle to REGISTERS.
- R15 update priority, per edge:
  1. RESET
  2. WRITE_ENABLE with WRITE_ADDRESS=15: R15 ← WRITE_DATA (branch; overrides PC_NEXT even when PC_ENABLE=1)
  3. PC_ENABLE: R15 ← PC_NEXT
  4. otherwise hold
- A write to Rw (w<15) and a PC_ENABLE update in the same cycle both take effect.
- Reads: combinational. raw_x = REGISTERS[READ_ADDRESS_x], selected by a 16:1 four-bit-select mux.
  - If BYPASS=1, WRITE_ENABLE=1 and WRITE_ADDRESS = READ_ADDRESS_x, then raw_x = WRITE_DATA.
  - Forwarding applies to R15 as well.
  - Forwarding never applies while RESET=1.
- R15 offset: if READ_ADDRESS_x=15, READ_DATA_x = raw_x + PC_READ_OFFSET, truncated to BITS (wrap-around, no carry out). Otherwise READ_DATA_x = raw_x.
- Both ports may address the same register; each gets the same value.
- Unwritten registers hold their value indefinitely.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package regbank_pkg holds:
  - REG_COUNT=16
  - REG_INDEX_BITS=4
  - PC_INDEX=15
  - typedef reg_index_t (logic [3:0])
- Natural sub-module: one read-port slice, n_bits_register_read_port (16:1 mux + bypass compare + R15 offset adder), instantiated twice.
- The bank itself contains the write decoder and the sixteen registers.

Test Plan:
- Reset: preload all registers with 0xFFFFFFFF, assert RESET with WRITE_ENABLE=1, addr 3, data 0x55 → next cycle REGISTERS all 0; READ_ADDRESS_A=15 gives READ_DATA_A=0x00000008.
- Write/read: write R5=0x12345678 → READ_DATA_A(addr 5)=0x12345678 one cycle later. Same cycle with BYPASS=1: READ_DATA_B(addr 5)=0x12345678 combinationally; with BYPASS=0: READ_DATA_B shows the old value.
- PC advance/stall: PC_ENABLE=1, PC_NEXT=0x100 → R15=0x100, READ_DATA_A(addr 15)=0x108. Then PC_ENABLE=0, PC_NEXT=0x104 → R15 stays 0x100.
- Branch priority: PC_ENABLE=1, PC_NEXT=0x200, WRITE_ENABLE=1, addr 15, data 0x400 → R15=0x400.
- Wrap-around: R15 written 0xFFFFFFFC → READ_DATA_B(addr 15)=0x00000004; REGISTERS[15]=0xFFFFFFFC.
- Simultaneous: write R14=0xA while PC_ENABLE loads 0x20, both ports reading 14 → next cycle R14=0xA, R15=0x20, READ_DATA_A=READ_DATA_B=0xA.
